mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_AW, default 14: implemented byte-address width; addr[MEM_AW-1:2] selects the word.
REQ-002 SHALL have parameter LOCK_MAX, default 16: maximum consecutive locked-idle cycles before a forced release.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL have ports req_valid0/req_valid1, input, 1 each: requester n presents a transaction.
REQ-006 SHALL have ports req_wr0/req_wr1, input, 1 each: 1 = write, 0 = read.
REQ-007 SHALL have ports req_lock0/req_lock1, input, 1 each: hold ownership after this transaction.
REQ-008 SHALL have ports req_addr0/req_addr1, input, 32 each: byte address.
REQ-009 SHALL have ports req_wdata0/req_wdata1, input, 32 each: write data.
REQ-010 SHALL have ports gnt0/gnt1, output, 1 each: combinational; the transaction is accepted this cycle.
REQ-011 SHALL have ports resp_valid0/resp_valid1, output, 1 each: registered; one-cycle completion pulse.
REQ-012 SHALL have ports resp_rdata0/resp_rdata1, output, 32 each: registered read data.
REQ-013 SHALL have ports resp_err0/resp_err1, output, 1 each: registered; address error flag.
REQ-014 SHALL have port lock_timeout, output, 1: registered; one-cycle pulse on a forced release.
REQ-015 SHALL have memory-side ports data_addr (output, 32), data_in (output, 32), wr_en (output, 1) and data_out (input, 32); data_out is a combinational read of the memory.

Function
REQ-016 SHALL assert at most one of gnt0/gnt1 per cycle; gntn SHALL never be asserted while req_validn = 0.
REQ-017 SHALL, in state IDLE with both requesters valid, grant the requester indicated by the rr pointer; with one requester valid, that requester is granted.
REQ-018 SHALL set the rr pointer to the non-granted requester after every grant.
REQ-019 SHALL drive data_addr and data_in from the granted requester and drive data_addr = 0 when nothing is granted.
REQ-020 SHALL assert wr_en only when a write is granted and carries no error.
REQ-021 SHALL, for every grant, register a response to the same requester in the next cycle: resp_validn = 1, resp_rdatan = data_out sampled at the grant (0 for writes), resp_errn = error flag.
REQ-022 SHALL hold resp_rdatan/resp_errn between pulses and SHALL reset them to 0.
REQ-023 SHALL have a state machine with states IDLE, LOCK0 and LOCK1.
REQ-024 SHALL move IDLE -> LOCKn when requester n is granted with req_lockn = 1.
REQ-025 SHALL, in LOCKn, grant only requester n; the other requester is stalled regardless of the rr pointer.
REQ-026 SHALL move LOCKn -> IDLE when requester n is granted with req_lockn = 0.
REQ-027 SHALL count consecutive LOCKn cycles without a grant; at count = LOCK_MAX it SHALL go to IDLE, pulse lock_timeout for one cycle and set the rr pointer to the other requester.
REQ-028 SHALL reset the lock counter on every grant and on entry to IDLE.
REQ-029 SHALL, when a grant and a timeout coincide, honour the grant and not take the timeout.
REQ-030 SHALL accept back-to-back grants on consecutive cycles, giving one transaction per cycle of throughput.

Reset
REQ-031 SHALL, while reset = 1, hold state IDLE, rr pointer = 0, lock counter = 0, all resp_* = 0, lock_timeout = 0, and gnt0/gnt1/wr_en = 0.
REQ-032 SHALL discard any response pending from a grant made in the reset cycle and release any lock held at reset.

Configuration
REQ-033 SHALL, with macro MEM_ARB_ADDR_CHECK_EN defined, flag an error when addr[1:0] != 0 or any addr[31:MEM_AW] bit is set: a flagged write is suppressed (wr_en = 0), a flagged read returns rdata = 0, and both complete with resp_err = 1.
REQ-034 SHALL, without MEM_ARB_ADDR_CHECK_EN, force resp_err0/resp_err1 to 0 and pass addresses through unchecked.

Verification
REQ-035 SHALL verify: both valid reads every cycle from reset, addr0 = 0x10, addr1 = 0x20 -> grants alternate 0,1,0,1; each resp_valid arrives one cycle after its grant with the correct word.
REQ-036 SHALL verify: requester 0 writes 0xDEADBEEF to 0x40 with lock = 1, then reads 0x40 with lock = 0, while requester 1 is valid throughout -> gnt1 = 0 until the unlocking read; the read returns 0xDEADBEEF.
REQ-037 SHALL verify: requester 1 locks, then drops valid for 16 cycles -> lock_timeout pulses once, the state returns to IDLE and requester 0 is granted the next cycle.
REQ-038 SHALL verify: with MEM_ARB_ADDR_CHECK_EN defined, a write to 0x4002 and a read from 0x00004000 -> wr_en stays 0, resp_err = 1 and rdata = 0 for both.
REQ-039 SHALL verify: reset asserted in the cycle of a grant while LOCK0 is held -> no resp_valid the next cycle, the state is IDLE and requester 1 is grantable.
REQ-040 SHALL verify: requester 0 alone issues 8 consecutive writes -> 8 consecutive grants and memory contents match.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-port word memory.
//
// Round-robin between requester 0 and 1 while idle; a requester that sets
// req_lockN on an accepted transaction keeps exclusive ownership until it
// issues a transaction with req_lockN = 0, or until it has left the bus idle
// for LOCK_MAX consecutive cycles (forced release, lock_timeout pulse).
//
// Handshake: a requester holds req_validN and its payload stable until it
// sees gntN = 1 in the same cycle; that cycle the transaction is accepted
// and its response (resp_validN pulse, rdata, err) appears one cycle later.
// gntN is combinational from the request inputs and never depends on a
// response being consumed, so one transaction per cycle is possible.
//
// Optional feature: define MEM_ARB_ADDR_CHECK_EN to flag misaligned or
// out-of-range addresses (write suppressed, read data 0, resp_err = 1).
//
// Parameters:
//   MEM_AW    implemented byte-address width (addr[MEM_AW-1:2] is the word)
//   LOCK_MAX  idle locked cycles before a forced release
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   req_valid/wr/lock/addr/wdataN  requester N transaction
//   gntN                           combinational accept
//   resp_validN/rdataN/errN        registered completion
//   lock_timeout                   registered pulse on forced release
//   data_addr/data_in/wr_en        memory request (from the granted requester)
//   data_out                       combinational memory read data
//   dbg_state                      FSM state (0 IDLE, 1 LOCK0, 2 LOCK1)
module mem_arbiter #(
  parameter int MEM_AW   = 14,
  parameter int LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid0,
  input  logic        req_valid1,
  input  logic        req_wr0,
  input  logic        req_wr1,
  input  logic        req_lock0,
  input  logic        req_lock1,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        resp_valid0,
  output logic        resp_valid1,
  output logic [31:0] resp_rdata0,
  output logic [31:0] resp_rdata1,
  output logic        resp_err0,
  output logic        resp_err1,
  output logic        lock_timeout,
  output logic [31:0] data_addr,
  output logic [31:0] data_in,
  output logic        wr_en,
  input  logic [31:0] data_out,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             timeout_d;
  logic             err0, err1;
  logic             gnt_wr, gnt_err;
  logic [31:0]      rdata_d;

  // Address error flags per requester.
`ifdef MEM_ARB_ADDR_CHECK_EN
  assign err0 = (req_addr0[1:0] != 2'b00) || (|(req_addr0 >> MEM_AW));
  assign err1 = (req_addr1[1:0] != 2'b00) || (|(req_addr1 >> MEM_AW));
`else
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

  // Grant selection and next-state logic.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    state_d    = state_q;
    rr_d       = rr_q;
    lock_cnt_d = lock_cnt_q;
    timeout_d  = 1'b0;
    if (!reset) begin
      unique case (state_q)
        LOCK0:   gnt0 = req_valid0;
        LOCK1:   gnt1 = req_valid1;
        default: begin
          if (req_valid0 && req_valid1) begin
            gnt0 = ~rr_q;
            gnt1 = rr_q;
          end else begin
            gnt0 = req_valid0;
            gnt1 = req_valid1;
          end
        end
      endcase

      if (gnt0) begin
        rr_d       = 1'b1;
        lock_cnt_d = '0;
        state_d    = req_lock0 ? LOCK0 : IDLE;
      end else if (gnt1) begin
        rr_d       = 1'b0;
        lock_cnt_d = '0;
        state_d    = req_lock1 ? LOCK1 : IDLE;
      end else if (state_q != IDLE) begin
        // This is the LOCK_MAX-th consecutive idle locked cycle: release.
        // A grant in the same cycle takes the branches above instead.
        if (lock_cnt_q == CNT_W'(LOCK_MAX - 1)) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
          timeout_d  = 1'b1;
          rr_d       = (state_q == LOCK0);
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
    end
  end

  // Memory request mux from the granted requester.
  always_comb begin
    data_addr = '0;
    data_in   = '0;
    gnt_wr    = 1'b0;
    gnt_err   = 1'b0;
    if (gnt0) begin
      data_addr = req_addr0;
      data_in   = req_wdata0;
      gnt_wr    = req_wr0;
      gnt_err   = err0;
    end else if (gnt1) begin
      data_addr = req_addr1;
      data_in   = req_wdata1;
      gnt_wr    = req_wr1;
      gnt_err   = err1;
    end
    wr_en   = gnt_wr && !gnt_err;
    rdata_d = (gnt_wr || gnt_err) ? 32'h0 : data_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      lock_cnt_q   <= '0;
      lock_timeout <= 1'b0;
      resp_valid0  <= 1'b0;
      resp_valid1  <= 1'b0;
      resp_rdata0  <= 32'h0;
      resp_rdata1  <= 32'h0;
      resp_err0    <= 1'b0;
      resp_err1    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      lock_cnt_q   <= lock_cnt_d;
      lock_timeout <= timeout_d;
      resp_valid0  <= gnt0;
      resp_valid1  <= gnt1;
      // rdata/err hold their value between completions.
      if (gnt0) begin
        resp_rdata0 <= rdata_d;
        resp_err0   <= gnt_err;
      end
      if (gnt1) begin
        resp_rdata1 <= rdata_d;
        resp_err1   <= gnt_err;
      end
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level reference model
// (owner / round-robin / idle-count bookkeeping plus a model memory).
module tb_mem_arbiter;

  localparam int MEM_AW   = 14;
  localparam int LOCK_MAX = 16;
  localparam int WORDS    = 1 << (MEM_AW - 2);
`ifdef MEM_ARB_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUT signals ----------------
  logic [1:0]  v, wr, lk;
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic        gnt0, gnt1, resp_valid0, resp_valid1, resp_err0, resp_err1;
  logic [31:0] resp_rdata0, resp_rdata1;
  logic        lock_timeout, wr_en;
  logic [31:0] data_addr, data_in, data_out;
  logic [1:0]  dbg_state;

  mem_arbiter #(.MEM_AW(MEM_AW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(rst),
    .req_valid0(v[0]), .req_valid1(v[1]),
    .req_wr0(wr[0]), .req_wr1(wr[1]),
    .req_lock0(lk[0]), .req_lock1(lk[1]),
    .req_addr0(ad[0]), .req_addr1(ad[1]),
    .req_wdata0(wd[0]), .req_wdata1(wd[1]),
    .gnt0(gnt0), .gnt1(gnt1),
    .resp_valid0(resp_valid0), .resp_valid1(resp_valid1),
    .resp_rdata0(resp_rdata0), .resp_rdata1(resp_rdata1),
    .resp_err0(resp_err0), .resp_err1(resp_err1),
    .lock_timeout(lock_timeout),
    .data_addr(data_addr), .data_in(data_in), .wr_en(wr_en),
    .data_out(data_out),
    .dbg_state(dbg_state)
  );

  // ---------------- memory attached to the DUT ----------------
  function automatic logic [31:0] init_word(input int i);
    return 32'(i) * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  logic [31:0] mem [WORDS];
  bit          mem_loaded = 1'b0;
  assign data_out = mem[data_addr[MEM_AW-1:2]];
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (wr_en) begin
      mem[data_addr[MEM_AW-1:2]] <= data_in;
    end
  end

  // ---------------- reference model state ----------------
  logic [31:0] ref_mem [WORDS];
  int          owner;      // -1 = nobody holds a lock
  int          m_rr;       // requester preferred on a tie
  int          idle_cnt;   // consecutive locked cycles with no grant
  logic        exp_vld [2];
  logic [31:0] exp_rd  [2];
  logic        exp_er  [2];
  logic        exp_to;
  int          n_to;       // observed lock_timeout pulses

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic model_err(input logic [31:0] a);
    return CHECK_EN && ((a % 4 != 0) || (64'(a) >= (64'd1 << MEM_AW)));
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % WORDS);
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  // ---------------- driver helpers ----------------
  task automatic set_req(input int p, input logic val, input logic w, input logic l,
                         input logic [31:0] a, input logic [31:0] d);
    v[p]  = val;
    wr[p] = w;
    lk[p] = l;
    ad[p] = a;
    wd[p] = d;
  endtask

  task automatic idle_inputs();
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // One clock cycle: predict, check at the falling edge, advance the model.
  task automatic step();
    int   g;
    logic e;
    int   w;
    g = -1;
    if (!rst) begin
      if (owner >= 0)            g = v[owner] ? owner : -1;
      else if (v[0] && v[1])     g = m_rr;
      else if (v[0])             g = 0;
      else if (v[1])             g = 1;
    end
    e = (g >= 0) ? model_err(ad[g]) : 1'b0;

    @(negedge clk);
    chk("gnt0", 32'(gnt0), 32'(g == 0));
    chk("gnt1", 32'(gnt1), 32'(g == 1));
    chk("wr_en", 32'(wr_en), 32'((g >= 0) && wr[g] && !e));
    chk("data_addr", data_addr, (g >= 0) ? ad[g] : 32'h0);
    if (g >= 0) chk("data_in", data_in, wd[g]);
    chk("resp_valid0", 32'(resp_valid0), 32'(exp_vld[0]));
    chk("resp_valid1", 32'(resp_valid1), 32'(exp_vld[1]));
    chk("resp_rdata0", resp_rdata0, exp_rd[0]);
    chk("resp_rdata1", resp_rdata1, exp_rd[1]);
    chk("resp_err0", 32'(resp_err0), 32'(exp_er[0]));
    chk("resp_err1", 32'(resp_err1), 32'(exp_er[1]));
    chk("lock_timeout", 32'(lock_timeout), 32'(exp_to));
    chk("state", 32'(dbg_state), 32'(owner + 1));
    if (lock_timeout === 1'b1) n_to++;

    @(posedge clk);
    if (rst) begin
      owner = -1; m_rr = 0; idle_cnt = 0; exp_to = 1'b0;
      for (int p = 0; p < 2; p++) begin
        exp_vld[p] = 1'b0; exp_rd[p] = 32'h0; exp_er[p] = 1'b0;
      end
    end else begin
      exp_vld[0] = 1'b0;
      exp_vld[1] = 1'b0;
      exp_to     = 1'b0;
      if (g >= 0) begin
        w          = word_of(ad[g]);
        exp_vld[g] = 1'b1;
        exp_rd[g]  = (wr[g] || e) ? 32'h0 : ref_mem[w];
        exp_er[g]  = e;
        if (wr[g] && !e) ref_mem[w] = wd[g];
        m_rr     = 1 - g;
        idle_cnt = 0;
        owner    = lk[g] ? g : -1;
      end else if (owner >= 0) begin
        idle_cnt++;
        if (idle_cnt == LOCK_MAX) begin
          m_rr     = 1 - owner;
          owner    = -1;
          idle_cnt = 0;
          exp_to   = 1'b1;
        end
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
      1:       return 32'h0000_4000 + 32'($urandom_range(0, 15) * 4);
      2:       return 32'h8000_0000 | 32'($urandom_range(0, 15) * 4);
      default: return 32'($urandom_range(0, 63) * 4);
    endcase
  endfunction

  task automatic rand_traffic(input int cycles, input int idle_odds);
    for (int c = 0; c < cycles; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      for (int p = 0; p < 2; p++)
        set_req(p, $urandom_range(0, idle_odds) == 0 ? 1'b0 : 1'b1,
                1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
                rand_addr(), $urandom);
      step();
    end
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] wdat [8];

  initial begin
    owner = -1; m_rr = 0; idle_cnt = 0; exp_to = 1'b0; n_to = 0;
    for (int p = 0; p < 2; p++) begin
      exp_vld[p] = 1'b0; exp_rd[p] = 32'h0; exp_er[p] = 1'b0;
    end
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;

    // Reset state, with requests present that must not be granted.
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h55);
    step();
    step();
    rst = 1'b0;

    // Both requesters reading every cycle: grants alternate 0,1,0,1...
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 6; i++) step();

    // Requester 0 locked write then unlocking read; requester 1 stalls.
    set_req(0, 1'b1, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
    step();
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) step();
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    step();
    chk("lock_read_data", resp_rdata0, 32'hDEADBEEF);
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();

    // Requester 1 locks and goes quiet: forced release after LOCK_MAX cycles.
    idle_inputs();
    step();
    n_to = 0;
    set_req(1, 1'b1, 1'b0, 1'b1, 32'h24, 32'h0);
    step();
    set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h14, 32'h0);
    for (int i = 0; i < LOCK_MAX; i++) step();
    step();
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();
    chk("timeout_pulses", 32'(n_to), 32'd1);

    // Grant arriving on the last idle locked cycle wins over the timeout.
    n_to = 0;
    set_req(1, 1'b1, 1'b1, 1'b1, 32'h28, 32'hA5A5_0001);
    step();
    set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < LOCK_MAX - 1; i++) step();
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h28, 32'h0);
    step();
    idle_inputs();
    step();
    step();
    chk("no_timeout_on_grant", 32'(n_to), 32'd0);

    // Reset arriving while LOCK0 is held and a grant is pending.
    set_req(0, 1'b1, 1'b1, 1'b1, 32'h80, 32'h0BAD_F00D);
    step();
    rst = 1'b1;
    set_req(0, 1'b1, 1'b0, 1'b1, 32'h80, 32'h0);
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h84, 32'h0);
    step();
    rst = 1'b0;
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    idle_inputs();
    step();

    // Requester 0 alone: 8 back-to-back writes, then read them back.
    for (int i = 0; i < 8; i++) begin
      wdat[i] = $urandom;
      set_req(0, 1'b1, 1'b1, 1'b0, 32'h200 + 32'(4 * i), wdat[i]);
      step();
    end
    idle_inputs();
    step();
    for (int i = 0; i < 8; i++)
      chk("mem_contents", mem[word_of(32'h200 + 32'(4 * i))], wdat[i]);
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1'b1, 1'b0, 1'b0, 32'h200 + 32'(4 * i), 32'h0);
      step();
    end
    idle_inputs();
    step();

    // Misaligned write and out-of-range read.
    set_req(0, 1'b1, 1'b1, 1'b0, 32'h0000_4002, 32'hCAFE_0001);
    step();
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h0000_4000, 32'h0);
    step();
    idle_inputs();
    step();

    // Random traffic: busy mix, then sparse traffic that lets locks time out.
    rand_traffic(300, 3);
    rand_traffic(300, 1);
    idle_inputs();
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
